// File: rtl/outport_alloc.sv
// Wormhole output-port allocator: round-robin grant held for a whole frame,
// with a stall watchdog that drains a stuck frame and reports it.
module outport_alloc #(
    parameter int N   = 4,
    parameter int SW  = 2,
    parameter int TMO = 64,
    parameter int CW  = 7
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic [N-1:0]  req,
    input  logic [N-1:0]  vld,
    input  logic [N-1:0]  eof,
    output logic [N-1:0]  ack,
    output logic [N-1:0]  gnt,
    output logic [SW-1:0] sel,
    output logic          o_vld,
    output logic          o_eof,
    input  logic          o_rdy,
    output logic          tmo_err
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOCK  = 2'd1,
        FLUSH = 2'd2
    } state_t;

    localparam logic [CW-1:0] TMO_LAST = CW'((TMO > 0) ? TMO - 1 : 0);

    state_t        state_q, state_d;
    logic [N-1:0]  gnt_q, gnt_d;
    logic [SW-1:0] sel_q, sel_d;
    logic [SW-1:0] ptr_q, ptr_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          tmo_err_q, tmo_err_d;

    logic [SW-1:0] winner;
    logic          found;
    logic          req_sel, vld_sel, eof_sel;
    logic          xfer;
    logic          rel_frame;

    function automatic logic [SW-1:0] wrap_add(input logic [SW-1:0] a, input int b);
        int s;
        s = int'(a) + b;
        if (s >= N) s = s - N;
        return SW'(s);
    endfunction

    assign req_sel = req[sel_q];
    assign vld_sel = vld[sel_q];
    assign eof_sel = eof[sel_q];
    assign xfer    = (state_q == LOCK) && vld_sel && o_rdy;

    assign o_vld   = (state_q == LOCK) && vld_sel;
    assign o_eof   = o_vld && eof_sel;
    assign gnt     = gnt_q;
    assign sel     = sel_q;
    assign tmo_err = tmo_err_q;

    // Only the selected input is ever acked; FLUSH drains it without the link.
    genvar gi;
    generate
        for (gi = 0; gi < N; gi++) begin : g_ack
            assign ack[gi] = (sel_q == SW'(gi)) && vld[gi] &&
                             (((state_q == LOCK) && o_rdy) || (state_q == FLUSH));
        end
    endgenerate

    // Round-robin search starting at the pointer.
    always_comb begin
        winner = '0;
        found  = 1'b0;
        for (int k = 0; k < N; k++) begin
            if (!found && req[wrap_add(ptr_q, k)]) begin
                found  = 1'b1;
                winner = wrap_add(ptr_q, k);
            end
        end
    end

    always_comb begin
        state_d   = state_q;
        gnt_d     = gnt_q;
        sel_d     = sel_q;
        ptr_d     = ptr_q;
        cnt_d     = cnt_q;
        tmo_err_d = 1'b0;
        rel_frame = 1'b0;
        case (state_q)
            IDLE: begin
                if (found) begin
                    gnt_d         = '0;
                    gnt_d[winner] = 1'b1;
                    sel_d         = winner;
                    cnt_d         = '0;
                    state_d       = LOCK;
                end
            end
            LOCK: begin
                // Abort is checked before the watchdog so a dropped request never flushes.
                if ((xfer && eof_sel) || !req_sel) begin
                    rel_frame = 1'b1;
                end else if (xfer) begin
                    cnt_d = '0;
                end else if ((TMO != 0) && (cnt_q == TMO_LAST)) begin
                    state_d   = FLUSH;
                    tmo_err_d = 1'b1;
                end else if (cnt_q != '1) begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            FLUSH: begin
                if ((vld_sel && eof_sel) || !req_sel) rel_frame = 1'b1;
            end
            default: state_d = IDLE;
        endcase
        if (rel_frame) begin
            gnt_d   = '0;
            ptr_d   = wrap_add(sel_q, 1);
            state_d = IDLE;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            gnt_q     <= '0;
            sel_q     <= '0;
            ptr_q     <= '0;
            cnt_q     <= '0;
            tmo_err_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            gnt_q     <= gnt_d;
            sel_q     <= sel_d;
            ptr_q     <= ptr_d;
            cnt_q     <= cnt_d;
            tmo_err_q <= tmo_err_d;
        end
    end

endmodule
